// File: rtl/mmio_initiator.sv
// Bus master for the IO-mapped device bus: one load/store per request, each beat
// paced to the responder's address pipeline, misaligned words split into two bytes.
module mmio_initiator #(
    parameter int unsigned SETUP_CYCLES = 2
) (
    input  logic        main_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [31:0] address_io,
    output logic [1:0]  control_io,
    output logic [15:0] data_in_io,
    input  logic [15:0] data_out_io
);

    localparam int unsigned CW = (SETUP_CYCLES > 0) ? $clog2(SETUP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_SUB = CW'(SETUP_CYCLES);

    typedef enum logic [1:0] {IDLE, BEAT_A, BEAT_B, RESP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] sub;
    logic          wr_q, byte_q, split_q;
    logic [31:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [7:0]    byte_a_q;
    logic [15:0]   rdata_q;
    logic          accept, last_sub, in_beat;

    assign accept   = req_valid && req_ready;
    assign last_sub = (sub == LAST_SUB);
    assign in_beat  = (state == BEAT_A) || (state == BEAT_B);

    // req_ready is a flop loaded from the next state so it stays low through reset
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sub       <= '0;
            req_ready <= 1'b0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == IDLE);
            if (in_beat && !last_sub)
                sub <= sub + CW'(1);
            else
                sub <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_addr[31] ? BEAT_A : RESP;
            BEAT_A:  if (last_sub) state_next = split_q ? BEAT_B : RESP;
            BEAT_B:  if (last_sub) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            wr_q     <= 1'b0;
            byte_q   <= 1'b0;
            split_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            byte_a_q <= '0;
            rdata_q  <= '0;
        end else if (accept) begin
            wr_q    <= req_write;
            byte_q  <= req_byte;
            split_q <= !req_byte && req_addr[0];
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
        end else if (last_sub && !wr_q) begin
            // Read data is sampled on the final sub-cycle, when the pipeline has settled
            if (state == BEAT_A) begin
                byte_a_q <= data_out_io[7:0];
                if (!split_q)
                    rdata_q <= byte_q ? {8'h00, data_out_io[7:0]} : data_out_io;
            end else if (state == BEAT_B) begin
                rdata_q <= {data_out_io[7:0], byte_a_q};
            end
        end
    end

    always_comb begin
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        address_io = '0;
        control_io = '0;
        data_in_io = '0;
        case (state)
            BEAT_A: begin
                address_io = addr_q;
                control_io = {wr_q && last_sub, byte_q || split_q};
                data_in_io = wdata_q;
            end
            BEAT_B: begin
                address_io = addr_q + 32'd1;
                control_io = {wr_q && last_sub, 1'b1};
                data_in_io = {8'h00, wdata_q[15:8]};
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

endmodule
